// File: rtl/axi_lite_boot_cfg_sequencer.sv
// axi_lite_boot_cfg_sequencer: walks a config table issuing one AXI4-Lite write per entry
module axi_lite_boot_cfg_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_ENTRIES    = 8,
    parameter int IDX_WIDTH      = 3,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_WIDTH       = 9
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [IDX_WIDTH-1:0]    err_idx,
    output logic [IDX_WIDTH-1:0]    tbl_idx,
    input  logic [ADDR_WIDTH-1:0]   tbl_addr,
    input  logic [DATA_WIDTH-1:0]   tbl_data,
    input  logic [DATA_WIDTH/8-1:0] tbl_strb,
    input  logic                    tbl_last,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_B, DONE, ERR} state_t;

    state_t              state, state_nx;
    logic                aw_ok, w_ok;
    logic [TO_WIDTH-1:0] cnt;
    logic                aw_done, w_done, to_hit, last_ent, bad_resp, can_start;

    // valids and bready decode straight from registered state so reset drops them at once
    assign busy          = (state == ISSUE) || (state == WAIT_B);
    assign m_axi_awvalid = (state == ISSUE) && !aw_ok;
    assign m_axi_wvalid  = (state == ISSUE) && !w_ok;
    assign m_axi_bready  = (state == WAIT_B);
    assign m_axi_awaddr  = tbl_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wdata   = tbl_data;
    assign m_axi_wstrb   = tbl_strb;
    assign aw_done       = aw_ok || (m_axi_awvalid && m_axi_awready);
    assign w_done        = w_ok || (m_axi_wvalid && m_axi_wready);
    assign to_hit        = (cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
    assign last_ent      = tbl_last || (tbl_idx == IDX_WIDTH'(NUM_ENTRIES - 1));
    assign bad_resp      = (m_axi_bresp != 2'b00);
    assign can_start     = start && !busy;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // next state: phase completion wins over timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: state_nx = can_start ? ISSUE : state;
            ISSUE:           state_nx = (aw_done && w_done) ? WAIT_B : to_hit ? ERR : ISSUE;
            WAIT_B:          state_nx = m_axi_bvalid ? (bad_resp ? ERR : last_ent ? DONE : ISSUE)
                                                     : to_hit ? ERR : WAIT_B;
            default:         state_nx = IDLE;
        endcase
    end

    // table index, handshake flags, phase timer and sticky status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_idx  <= '0;
            aw_ok    <= 1'b0;
            w_ok     <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
            err_idx  <= '0;
        end else if (state == ISSUE) begin
            aw_ok <= aw_done;
            w_ok  <= w_done;
            cnt   <= (aw_done && w_done) ? '0 : cnt + 1'b1;
            if (!(aw_done && w_done) && to_hit) begin
                error    <= 1'b1;
                err_code <= 2'b10;
                err_idx  <= tbl_idx;
            end
        end else if (state == WAIT_B) begin
            cnt <= m_axi_bvalid ? '0 : cnt + 1'b1;
            if (m_axi_bvalid) begin
                aw_ok <= 1'b0;
                w_ok  <= 1'b0;
                if (bad_resp) begin
                    error    <= 1'b1;
                    err_code <= 2'b01;
                    err_idx  <= tbl_idx;
                end else if (last_ent) begin
                    done <= 1'b1;
                end else begin
                    tbl_idx <= tbl_idx + 1'b1;
                end
            end else if (to_hit) begin
                error    <= 1'b1;
                err_code <= 2'b10;
                err_idx  <= tbl_idx;
            end
        end else if (can_start) begin
            tbl_idx  <= '0;
            aw_ok    <= 1'b0;
            w_ok     <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
        end
    end
endmodule
